// File: rtl/branch_resolve_queue.sv
// Execute-side branch resolve queue: matches in-flight predictions with
// actual outcomes, trains the predictor, flushes on mispredict, keeps stats.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iPredValid,
  input  logic                     iPredTaken,
  input  logic [PC_W-1:0]          iTargetPC,
  input  logic [PC_W-1:0]          iFallPC,
  output logic                     oPredReady,
  input  logic                     iResValid,
  input  logic                     iResTaken,
  output logic                     oUpdValid,
  output logic                     oUpdTaken,
  output logic                     oFlush,
  output logic [PC_W-1:0]          oRedirectPC,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic [CNT_W-1:0]         oBranchCnt,
  output logic [CNT_W-1:0]         oMispredCnt,
  output logic                     oErr
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {RUN, RECOVER} state_t;

  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] fall;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   rd;
  logic [AW-1:0]   wr;
  state_t          state;
  state_t          state_nxt;
  logic            push;
  logic            res;
  logic            mis;

  assign oPredReady = (state == RUN) && (oCount < (AW+1)'(DEPTH));
  assign head = mem[rd];
  assign push = iPredValid && oPredReady;
  assign res  = iResValid && (oCount != '0);
  assign mis  = res && (head.taken != iResTaken);

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (mis) state_nxt = RECOVER;
      RECOVER: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) state <= RUN;
    else      state <= state_nxt;
  end

  // A push racing a mispredict is wrong-path, so it is never stored.
  always_ff @(posedge iClk) begin
    if (push && !mis) mem[wr] <= '{iPredTaken, iTargetPC, iFallPC};
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rd     <= '0;
      wr     <= '0;
      oCount <= '0;
    end else if (mis) begin
      rd     <= '0;
      wr     <= '0;
      oCount <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (res)  rd <= rd + AW'(1);
      unique case ({push, res})
        2'b10:   oCount <= oCount + 1'b1;
        2'b01:   oCount <= oCount - 1'b1;
        default: oCount <= oCount;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oUpdValid   <= 1'b0;
      oUpdTaken   <= 1'b0;
      oFlush      <= 1'b0;
      oRedirectPC <= '0;
      oErr        <= 1'b0;
    end else begin
      oUpdValid <= res;
      oUpdTaken <= res && iResTaken;
      oFlush    <= mis;
      if (mis) oRedirectPC <= iResTaken ? head.target : head.fall;
      if (iResValid && oCount == '0) oErr <= 1'b1;
    end
  end

  // Mispredicts never outnumber branches, so branch saturates no later.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oBranchCnt  <= '0;
      oMispredCnt <= '0;
    end else begin
      if (res && oBranchCnt != '1)  oBranchCnt  <= oBranchCnt + 1'b1;
      if (mis && oMispredCnt != '1) oMispredCnt <= oMispredCnt + 1'b1;
    end
  end
endmodule
